// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared control-word type, RV32I opcodes, ALU/imm/forward encodings and decode helpers
package pipe_ctrl_pkg;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4, ALU_SLT = 3'd5, ALU_SLL = 3'd6, ALU_SRL = 3'd7;
    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4;
    typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_t;
    typedef struct packed {
        logic       reg_write;
        logic       result_src;
        logic       mem_write;
        logic       alu_src;
        logic [2:0] alu_control;
        logic [2:0] imm_src;
        logic       branch;
        logic       jlink;
        logic       pc_src_reg;
        logic       store_pc;
        logic       byte_op;
        logic       valid;
    } ctrl_t;
    function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  return sub ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLT;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
    function automatic ctrl_t decode(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        ctrl_t c;
        c = '0;
        c.valid = 1'b1;
        case (op)
            OP_LOAD:   begin c.reg_write = 1'b1; c.result_src = 1'b1; c.alu_src = 1'b1; c.byte_op = (f3 == 3'b000); end
            OP_STORE:  begin c.mem_write = 1'b1; c.alu_src = 1'b1; c.imm_src = IMM_S; c.byte_op = (f3 == 3'b000); end
            OP_R:      begin c.reg_write = 1'b1; c.alu_control = alu_op(f3, f7[5]); end
            OP_I:      begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_control = alu_op(f3, 1'b0); end
            OP_BRANCH: begin c.branch = 1'b1; c.alu_control = ALU_SUB; c.imm_src = IMM_B; end
            OP_JAL:    begin c.reg_write = 1'b1; c.jlink = 1'b1; c.store_pc = 1'b1; c.imm_src = IMM_J; end
            OP_JALR:   begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.pc_src_reg = 1'b1; c.store_pc = 1'b1; c.imm_src = IMM_I; end
            OP_LUI:    begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.imm_src = IMM_U; end
            default:   c = '0;
        endcase
        return c;
    endfunction
    // {uses rs2, uses rs1}; only real source reads may raise a hazard
    function automatic logic [1:0] src_use(input logic [6:0] op);
        return (op == OP_STORE || op == OP_R || op == OP_BRANCH) ? 2'b11 :
               (op == OP_LOAD || op == OP_I || op == OP_JALR) ? 2'b01 : 2'b00;
    endfunction
endpackage

// File: rtl/pipe_control_unit_if.sv
// pipe_control_unit_if: decode inputs (instr/valid/redirect) in, control words, reg indices, forward selects, stall/flush and stall count out
interface pipe_control_unit_if import pipe_ctrl_pkg::*; #(
    parameter int INSTR_WIDTH = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int CNT_W       = 32
);
    logic [INSTR_WIDTH-1:0] instr_d_i;
    logic                   valid_d_i;
    logic                   redirect_e_i;
    ctrl_t                  ctrl_d_o, ctrl_e_o, ctrl_m_o, ctrl_w_o;
    logic [REG_ADDR_W-1:0]  rs1_e_o, rs2_e_o, rd_e_o;
    fwd_t                   fwd_a_e_o, fwd_b_e_o;
    logic                   stall_f_o, stall_d_o, flush_d_o, flush_e_o;
    logic [CNT_W-1:0]       stall_cnt_o;
    modport master (
        output instr_d_i, valid_d_i, redirect_e_i,
        input  ctrl_d_o, ctrl_e_o, ctrl_m_o, ctrl_w_o, rs1_e_o, rs2_e_o, rd_e_o,
        input  fwd_a_e_o, fwd_b_e_o, stall_f_o, stall_d_o, flush_d_o, flush_e_o, stall_cnt_o
    );
    modport slave (
        input  instr_d_i, valid_d_i, redirect_e_i,
        output ctrl_d_o, ctrl_e_o, ctrl_m_o, ctrl_w_o, rs1_e_o, rs2_e_o, rd_e_o,
        output fwd_a_e_o, fwd_b_e_o, stall_f_o, stall_d_o, flush_d_o, flush_e_o, stall_cnt_o
    );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: combinational load-use/RAW stall, redirect flush and E-stage operand forward selection from stage write flags and register indices
module hazard_unit import pipe_ctrl_pkg::*; #(
    parameter int REG_ADDR_W = 5,
    parameter int FWD_EN     = 1
) (
    input  logic                  e_wr,
    input  logic                  e_ld,
    input  logic                  m_wr,
    input  logic                  w_wr,
    input  logic                  use_rs1,
    input  logic                  use_rs2,
    input  logic                  redirect,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rs1_e,
    input  logic [REG_ADDR_W-1:0] rs2_e,
    input  logic [REG_ADDR_W-1:0] rd_e,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic [REG_ADDR_W-1:0] rd_w,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_e,
    output fwd_t                  fwd_a,
    output fwd_t                  fwd_b
);
    logic hit_e, hit_m, hazard;
    function automatic fwd_t sel(input logic [REG_ADDR_W-1:0] rs);
        return (FWD_EN == 0 || rs == '0) ? FWD_RF :
               (m_wr && rd_m == rs) ? FWD_MEM :
               (w_wr && rd_w == rs) ? FWD_WB : FWD_RF;
    endfunction
    assign hit_e   = (rd_e != '0) && ((use_rs1 && rs1_d == rd_e) || (use_rs2 && rs2_d == rd_e));
    assign hit_m   = (rd_m != '0) && ((use_rs1 && rs1_d == rd_m) || (use_rs2 && rs2_d == rd_m));
    assign hazard  = (FWD_EN != 0) ? (e_ld && hit_e) : ((e_wr && hit_e) || (m_wr && hit_m));
    assign stall_f = hazard && !redirect;
    assign stall_d = hazard && !redirect;
    assign flush_d = redirect;
    assign flush_e = hazard || redirect;
    assign fwd_a   = sel(rs1_e);
    assign fwd_b   = sel(rs2_e);
endmodule

// File: rtl/pipe_control_unit.sv
// pipe_control_unit: RV32I decode plus D/E, E/M, M/W control pipeline with hazard handling; ports clk_i, rst_n_i (async, active-low) and the slave side of pipe_control_unit_if
module pipe_control_unit import pipe_ctrl_pkg::*; #(
    parameter int INSTR_WIDTH = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int FWD_EN      = 1,
    parameter int CNT_W       = 32
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    pipe_control_unit_if.slave bus
);
    logic [REG_ADDR_W-1:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    ctrl_t                 ctrl_d, ctrl_e, ctrl_m, ctrl_w;
    logic [1:0]            use_src;
    logic                  redirect, stall_d, flush_e;
    logic [CNT_W-1:0]      cnt;
    assign rs1_d    = bus.instr_d_i[15 +: REG_ADDR_W];
    assign rs2_d    = bus.instr_d_i[20 +: REG_ADDR_W];
    assign rd_d     = bus.instr_d_i[7 +: REG_ADDR_W];
    assign ctrl_d   = bus.valid_d_i ? decode(bus.instr_d_i[6:0], bus.instr_d_i[14:12], bus.instr_d_i[31:25]) : '0;
    assign use_src  = bus.valid_d_i ? src_use(bus.instr_d_i[6:0]) : 2'b00;
    // keeps flush low while reset is held
    assign redirect = bus.redirect_e_i && rst_n_i;
    hazard_unit #(.REG_ADDR_W(REG_ADDR_W), .FWD_EN(FWD_EN)) u_hazard (
        .e_wr    (ctrl_e.valid && ctrl_e.reg_write),
        .e_ld    (ctrl_e.valid && ctrl_e.result_src),
        .m_wr    (ctrl_m.valid && ctrl_m.reg_write),
        .w_wr    (ctrl_w.valid && ctrl_w.reg_write),
        .use_rs1 (use_src[0]),
        .use_rs2 (use_src[1]),
        .redirect(redirect),
        .rs1_d   (rs1_d),
        .rs2_d   (rs2_d),
        .rs1_e   (rs1_e),
        .rs2_e   (rs2_e),
        .rd_e    (rd_e),
        .rd_m    (rd_m),
        .rd_w    (rd_w),
        .stall_f (bus.stall_f_o),
        .stall_d (stall_d),
        .flush_d (bus.flush_d_o),
        .flush_e (flush_e),
        .fwd_a   (bus.fwd_a_e_o),
        .fwd_b   (bus.fwd_b_e_o)
    );
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ctrl_e <= '0;
            ctrl_m <= '0;
            ctrl_w <= '0;
            rs1_e  <= '0;
            rs2_e  <= '0;
            rd_e   <= '0;
            rd_m   <= '0;
            rd_w   <= '0;
            cnt    <= '0;
        end else begin
            ctrl_e <= flush_e ? '0 : ctrl_d;
            rs1_e  <= flush_e ? '0 : rs1_d;
            rs2_e  <= flush_e ? '0 : rs2_d;
            rd_e   <= flush_e ? '0 : rd_d;
            ctrl_m <= ctrl_e;
            ctrl_w <= ctrl_m;
            rd_m   <= rd_e;
            rd_w   <= rd_m;
            cnt    <= (stall_d && !(&cnt)) ? cnt + 1'b1 : cnt;
        end
    end
    assign bus.ctrl_d_o    = ctrl_d;
    assign bus.ctrl_e_o    = ctrl_e;
    assign bus.ctrl_m_o    = ctrl_m;
    assign bus.ctrl_w_o    = ctrl_w;
    assign bus.rs1_e_o     = rs1_e;
    assign bus.rs2_e_o     = rs2_e;
    assign bus.rd_e_o      = rd_e;
    assign bus.stall_d_o   = stall_d;
    assign bus.flush_e_o   = flush_e;
    assign bus.stall_cnt_o = cnt;
endmodule

// File: tb/tb_pipe_control_unit.sv
// tb_pipe_control_unit: table-driven decode/latency scoreboard plus hazard, forward, redirect, saturation and reset sequences
module tb_pipe_control_unit;
    import pipe_ctrl_pkg::*;
    typedef struct {
        logic [31:0] ins;
        logic        v;
        ctrl_t       exp;
    } vec_t;
    typedef struct {
        ctrl_t      c;
        logic [4:0] rd;
    } sb_t;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t tv [14];
    sb_t  eq [$];
    sb_t  mq [$];
    sb_t  wq [$];
    always #5 clk = ~clk;
    pipe_control_unit_if #(.INSTR_WIDTH(32), .REG_ADDR_W(5), .CNT_W(32)) b1 ();
    pipe_control_unit_if #(.INSTR_WIDTH(32), .REG_ADDR_W(5), .CNT_W(2))  b2 ();
    pipe_control_unit #(.FWD_EN(1)) u1 (.clk_i(clk), .rst_n_i(rst_n), .bus(b1));
    pipe_control_unit #(.FWD_EN(0), .CNT_W(2)) u2 (.clk_i(clk), .rst_n_i(rst_n), .bus(b2));
    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction
    function automatic ctrl_t mk(input logic rw, input logic rs, input logic mw, input logic as,
                                 input logic [2:0] alu, input logic [2:0] imm, input logic br, input logic jl,
                                 input logic pcr, input logic spc, input logic bo, input logic v);
        ctrl_t c;
        c.reg_write = rw; c.result_src = rs; c.mem_write = mw; c.alu_src = as;
        c.alu_control = alu; c.imm_src = imm; c.branch = br; c.jlink = jl;
        c.pc_src_reg = pcr; c.store_pc = spc; c.byte_op = bo; c.valid = v;
        return c;
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask
    task automatic drive(input logic [31:0] ins, input logic v, input logic r);
        b1.instr_d_i = ins; b1.valid_d_i = v; b1.redirect_e_i = r;
        b2.instr_d_i = ins; b2.valid_d_i = v; b2.redirect_e_i = r;
    endtask
    task automatic step(input logic [31:0] ins, input logic v, input logic r);
        @(posedge clk);
        #1;
        drive(ins, v, r);
        #1;
    endtask
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive('0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    initial begin
        logic [31:0] lw5, add6, addi3, add433;
        sb_t e, m;
        lw5    = enc(7'h00, 5'd0, 5'd1, 3'd2, 5'd5, 7'h03);
        add6   = enc(7'h00, 5'd2, 5'd5, 3'd0, 5'd6, 7'h33);
        addi3  = enc(7'h00, 5'd1, 5'd0, 3'd0, 5'd3, 7'h13);
        add433 = enc(7'h00, 5'd3, 5'd3, 3'd0, 5'd4, 7'h33);
        drive(enc(7'h00, 5'd3, 5'd2, 3'd0, 5'd1, 7'h33), 1'b1, 1'b1);
        #1 rst_n = 1'b0;
        #20;
        chk("rst_ctrl_e", b1.ctrl_e_o, 0);
        chk("rst_ctrl_m", b1.ctrl_m_o, 0);
        chk("rst_ctrl_w", b1.ctrl_w_o, 0);
        chk("rst_rd_rs", {b1.rd_e_o, b1.rs1_e_o, b1.rs2_e_o}, 0);
        chk("rst_stall", {b1.stall_f_o, b1.stall_d_o}, 0);
        chk("rst_flush", {b1.flush_d_o, b1.flush_e_o}, 0);
        chk("rst_fwd", {b1.fwd_a_e_o, b1.fwd_b_e_o}, 0);
        chk("rst_cnt", b1.stall_cnt_o, 0);
        @(posedge clk);
        #1;
        drive('0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tv[0]  = '{enc(7'h00, 5'd3, 5'd2, 3'd0, 5'd1, 7'h33), 1'b1, mk(1,0,0,0,3'd0,3'd0,0,0,0,0,0,1)};
        tv[1]  = '{enc(7'h20, 5'd6, 5'd5, 3'd0, 5'd4, 7'h33), 1'b1, mk(1,0,0,0,3'd1,3'd0,0,0,0,0,0,1)};
        tv[2]  = '{enc(7'h00, 5'd0, 5'd8, 3'd2, 5'd7, 7'h03), 1'b1, mk(1,1,0,1,3'd0,3'd0,0,0,0,0,0,1)};
        tv[3]  = '{enc(7'h00, 5'd9, 5'd10, 3'd0, 5'd4, 7'h23), 1'b1, mk(0,0,1,1,3'd0,3'd1,0,0,0,0,1,1)};
        tv[4]  = '{enc(7'h00, 5'd5, 5'd12, 3'd7, 5'd11, 7'h13), 1'b1, mk(1,0,0,1,3'd2,3'd0,0,0,0,0,0,1)};
        tv[5]  = '{enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd0, 7'h63), 1'b1, mk(0,0,0,0,3'd1,3'd2,1,0,0,0,0,1)};
        tv[6]  = '{enc(7'h00, 5'd0, 5'd0, 3'd0, 5'd1, 7'h6f), 1'b1, mk(1,0,0,0,3'd0,3'd3,0,1,0,1,0,1)};
        tv[7]  = '{enc(7'h00, 5'd0, 5'd1, 3'd0, 5'd0, 7'h67), 1'b1, mk(1,0,0,1,3'd0,3'd0,0,0,1,1,0,1)};
        tv[8]  = '{enc(7'h12, 5'd0, 5'd0, 3'd0, 5'd13, 7'h37), 1'b1, mk(1,0,0,1,3'd0,3'd4,0,0,0,0,0,1)};
        tv[9]  = '{enc(7'h00, 5'd0, 5'd0, 3'd0, 5'd0, 7'h7f), 1'b1, '0};
        tv[10] = '{enc(7'h00, 5'd3, 5'd2, 3'd0, 5'd1, 7'h33), 1'b0, '0};
        tv[11] = '{enc(7'h00, 5'd0, 5'd15, 3'd0, 5'd14, 7'h03), 1'b1, mk(1,1,0,1,3'd0,3'd0,0,0,0,0,1,1)};
        tv[12] = '{enc(7'h00, 5'd18, 5'd17, 3'd6, 5'd16, 7'h33), 1'b1, mk(1,0,0,0,3'd3,3'd0,0,0,0,0,0,1)};
        tv[13] = '{enc(7'h00, 5'd2, 5'd1, 3'd2, 5'd19, 7'h33), 1'b1, mk(1,0,0,0,3'd5,3'd0,0,0,0,0,0,1)};
        for (int i = 0; i < 17; i++) begin
            if (i < 14) step(tv[i].ins, tv[i].v, 1'b0);
            else step('0, 1'b0, 1'b0);
            if (wq.size() > 0) begin
                m = wq.pop_front();
                chk($sformatf("tv_w%0d", i), b1.ctrl_w_o, m.c);
            end
            if (mq.size() > 0) begin
                m = mq.pop_front();
                chk($sformatf("tv_m%0d", i), b1.ctrl_m_o, m.c);
                wq.push_back(m);
            end
            if (eq.size() > 0) begin
                e = eq.pop_front();
                chk($sformatf("tv_e%0d", i), b1.ctrl_e_o, e.c);
                chk($sformatf("tv_rd%0d", i), b1.rd_e_o, e.rd);
                mq.push_back(e);
            end
            if (i < 14) begin
                chk($sformatf("tv_d%0d", i), b1.ctrl_d_o, tv[i].exp);
                chk($sformatf("tv_nostall%0d", i), b1.stall_d_o, 0);
                eq.push_back('{tv[i].exp, tv[i].ins[11:7]});
            end
        end
        do_reset();
        step(lw5, 1'b1, 1'b0);
        chk("lu_pre", b1.stall_d_o, 0);
        step(add6, 1'b1, 1'b0);
        chk("lu_stall", {b1.stall_f_o, b1.stall_d_o, b1.flush_e_o, b1.flush_d_o}, 4'b1110);
        step(add6, 1'b1, 1'b0);
        chk("lu_release", b1.stall_d_o, 0);
        chk("lu_bubble", b1.ctrl_e_o.valid, 0);
        step('0, 1'b0, 1'b0);
        chk("lu_add_e", {b1.ctrl_e_o.valid, b1.rs1_e_o}, {1'b1, 5'd5});
        chk("lu_fwd", {b1.fwd_a_e_o, b1.fwd_b_e_o}, 4'b0100);
        chk("lu_cnt", b1.stall_cnt_o, 1);
        step(addi3, 1'b1, 1'b0);
        step(add433, 1'b1, 1'b0);
        chk("fw_nostall", b1.stall_d_o, 0);
        step('0, 1'b0, 1'b0);
        chk("fw_mem_both", {b1.fwd_a_e_o, b1.fwd_b_e_o}, 4'b1010);
        step(addi3, 1'b1, 1'b0);
        step(enc(7'h00, 5'd2, 5'd0, 3'd0, 5'd7, 7'h13), 1'b1, 1'b0);
        step(enc(7'h00, 5'd7, 5'd3, 3'd0, 5'd4, 7'h33), 1'b1, 1'b0);
        step('0, 1'b0, 1'b0);
        chk("fw_wb_mem", {b1.fwd_a_e_o, b1.fwd_b_e_o}, 4'b0110);
        step(addi3, 1'b1, 1'b0);
        step(enc(7'h00, 5'd2, 5'd0, 3'd0, 5'd3, 7'h13), 1'b1, 1'b0);
        step(enc(7'h00, 5'd0, 5'd3, 3'd0, 5'd4, 7'h33), 1'b1, 1'b0);
        step('0, 1'b0, 1'b0);
        chk("fw_mem_prio", {b1.fwd_a_e_o, b1.fwd_b_e_o}, 4'b1000);
        step(enc(7'h00, 5'd0, 5'd1, 3'd2, 5'd0, 7'h03), 1'b1, 1'b0);
        step(enc(7'h00, 5'd0, 5'd0, 3'd0, 5'd6, 7'h33), 1'b1, 1'b0);
        chk("x0_nostall", {b1.stall_d_o, b2.stall_d_o}, 0);
        step('0, 1'b0, 1'b0);
        chk("x0_fwd", {b1.fwd_a_e_o, b1.fwd_b_e_o}, 0);
        step(lw5, 1'b1, 1'b0);
        step(add6, 1'b0, 1'b0);
        chk("nv_nostall", b1.stall_d_o, 0);
        step(lw5, 1'b1, 1'b0);
        step(add6, 1'b1, 1'b1);
        chk("rd_flush", {b1.flush_d_o, b1.flush_e_o}, 2'b11);
        chk("rd_nostall", {b1.stall_f_o, b1.stall_d_o}, 0);
        step('0, 1'b0, 1'b0);
        chk("rd_bubble", b1.ctrl_e_o.valid, 0);
        chk("rd_cnt", b1.stall_cnt_o, 1);
        do_reset();
        step(addi3, 1'b1, 1'b0);
        step(add433, 1'b1, 1'b0);
        chk("nf_stall1", {b2.stall_d_o, b1.stall_d_o}, 2'b10);
        step(add433, 1'b1, 1'b0);
        chk("nf_stall2", b2.stall_d_o, 1);
        chk("nf_cnt1", b2.stall_cnt_o, 1);
        step(add433, 1'b1, 1'b0);
        chk("nf_release", b2.stall_d_o, 0);
        chk("nf_cnt2", b2.stall_cnt_o, 2);
        step('0, 1'b0, 1'b0);
        chk("nf_add_e", {b2.ctrl_e_o.valid, b2.rs1_e_o}, {1'b1, 5'd3});
        chk("nf_fwd", {b2.fwd_a_e_o, b2.fwd_b_e_o}, 0);
        do_reset();
        for (int p = 0; p < 5; p++) begin
            step(lw5, 1'b1, 1'b0);
            step(add6, 1'b1, 1'b0);
            chk($sformatf("sat_s1_%0d", p), b2.stall_d_o, 1);
            step(add6, 1'b1, 1'b0);
            chk($sformatf("sat_s2_%0d", p), b2.stall_d_o, 1);
            step(add6, 1'b1, 1'b0);
            chk($sformatf("sat_s3_%0d", p), b2.stall_d_o, 0);
            chk($sformatf("sat_cnt_%0d", p), b2.stall_cnt_o, (p == 0) ? 2 : 3);
        end
        step(lw5, 1'b1, 1'b0);
        step(add6, 1'b1, 1'b0);
        step(add6, 1'b1, 1'b0);
        chk("sat_hold_stall", b2.stall_d_o, 1);
        chk("sat_hold_cnt", b2.stall_cnt_o, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_cnt", b2.stall_cnt_o, 0);
        chk("mid_rst_valid", {b2.ctrl_e_o.valid, b2.ctrl_m_o.valid, b2.ctrl_w_o.valid}, 0);
        chk("mid_rst_stall", b2.stall_d_o, 0);
        @(posedge clk);
        #1;
        drive('0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(addi3, 1'b1, 1'b0);
        chk("post_rst_e0", b2.ctrl_e_o.valid, 0);
        step('0, 1'b0, 1'b0);
        chk("post_rst_e1", {b2.ctrl_e_o.valid, b2.ctrl_m_o.valid}, 2'b10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
